// File: rtl/pc_sequencer.sv
// Fetch/execute controller driving the PC select code and branch operand.
// Owns branch resolution, halt/resume and instruction-memory timeout faults.
module pc_sequencer #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             imem_ready,
    input  logic             exec_done,
    input  logic             stall,
    input  logic [1:0]       branch_type,
    input  logic             branch_cond,
    input  logic [63:0]      branch_offset,
    input  logic [63:0]      branch_target,
    input  logic             halt_req,
    input  logic             resume,
    output logic [1:0]       PS,
    output logic [63:0]      pc_in,
    output logic             fetch_req,
    output logic             ir_load,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] instret
);

    typedef enum logic [2:0] {
        BOOT  = 3'd0,
        FETCH = 3'd1,
        EXEC  = 3'd2,
        HALT  = 3'd3,
        FAULT = 3'd4
    } state_t;

    localparam logic [7:0] TO = 8'(TIMEOUT);

    state_t     state;
    state_t     next_state;
    logic [7:0] wait_cnt;
    logic [7:0] wait_next;
    logic       retire;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= BOOT;
            wait_cnt <= 8'd0;
            instret  <= '0;
        end else begin
            state    <= next_state;
            wait_cnt <= wait_next;
            if (retire)
                instret <= instret + 1'b1;
        end
    end

    always_comb begin
        next_state = state;
        wait_next  = wait_cnt;
        PS         = 2'b00;
        pc_in      = 64'd0;
        fetch_req  = 1'b0;
        ir_load    = 1'b0;
        halted     = 1'b0;
        fault      = 1'b0;
        retire     = 1'b0;
        unique case (state)
            BOOT: begin
                wait_next  = 8'd0;
                next_state = FETCH;
            end
            FETCH: begin
                fetch_req = 1'b1;
                if (!stall) begin
                    if (imem_ready) begin
                        ir_load    = 1'b1;
                        wait_next  = 8'd0;
                        next_state = EXEC;
                    end else begin
                        wait_next = wait_cnt + 8'd1;
                        if (wait_next == TO)
                            next_state = FAULT;
                    end
                end
            end
            EXEC: begin
                wait_next = 8'd0;
                // Update cycle: the only cycle PS may be non-zero
                if (exec_done && !stall) begin
                    retire     = 1'b1;
                    next_state = halt_req ? HALT : FETCH;
                    unique case (branch_type)
                        2'b00: PS = 2'b01;
                        2'b01: begin
                            PS    = 2'b11;
                            pc_in = branch_offset;
                        end
                        2'b10: begin
                            if (branch_cond) begin
                                PS    = 2'b11;
                                pc_in = branch_offset;
                            end else begin
                                PS = 2'b01;
                            end
                        end
                        2'b11: begin
                            PS    = 2'b10;
                            pc_in = branch_target;
                        end
                        default: PS = 2'b00;
                    endcase
                end
            end
            HALT: begin
                halted = 1'b1;
                if (resume)
                    next_state = FETCH;
            end
            FAULT: begin
                fault = 1'b1;
            end
            default: begin
                wait_next  = 8'd0;
                next_state = BOOT;
            end
        endcase
    end

endmodule
